// File: rtl/lock_code_sender.sv
// lock_code_sender
// Driving end of the two-button electronic-lock interface. On an accepted
// start it replays a latched CODE_LEN-bit code onto the b0/b1 press lines,
// MSB first, one press of PRESS_CYCLES periods per bit, each optionally
// followed by GAP_CYCLES periods with both buttons released. It then waits
// up to TIMEOUT periods for the lock's unlock flag and reports the result.
//
// Ports:
//   clk      system clock, all state changes on posedge
//   reset    asynchronous active-low reset (low = reset asserted)
//   start    request an attempt, sampled only in IDLE
//   abort    cancel the attempt in progress (no done pulse)
//   code     code to send, latched on the accepted start
//   unlock   unlock flag from the lock
//   b0, b1   registered "0" / "1" button presses
//   busy     high from the accepted start until done or abort
//   done     one-cycle pulse at the end of an attempt
//   success  unlock seen during the attempt, held until the next start
//   fail     timeout without unlock, held until the next start

module lock_code_sender #(
   parameter int CODE_LEN     = 5,
   parameter int PRESS_CYCLES = 1,
   parameter int GAP_CYCLES   = 0,
   parameter int TIMEOUT      = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [CODE_LEN-1:0] code,
   input  logic                unlock,
   output logic                b0,
   output logic                b1,
   output logic                busy,
   output logic                done,
   output logic                success,
   output logic                fail
);

   localparam int MAX_PG  = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
   localparam int MAX_CNT = (MAX_PG > TIMEOUT) ? MAX_PG : TIMEOUT;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam int IW      = $clog2(CODE_LEN + 1);

   typedef enum logic [2:0] {IDLE, PRESS, GAP, WAIT, DONE} state_t;

   state_t              state;
   logic [CODE_LEN-1:0] shreg;
   logic [CODE_LEN-1:0] next_shreg;
   logic                next_bit;
   logic [IW-1:0]       bit_idx;
   logic [CW-1:0]       cnt;
   logic                seen;
   logic                last_bit;

   // The bit being pressed always sits in the MSB of shreg; the register is
   // shifted when a press ends, so after a gap the next bit is already in
   // place, while back-to-back presses take it from the shifted value.
   assign next_shreg = shreg << 1;
   assign next_bit   = next_shreg[CODE_LEN-1];

   // bit_idx is only decremented when the next press starts, so it stays 0
   // through the press and gap of the final bit.
   assign last_bit = (bit_idx == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         cnt     <= '0;
         seen    <= 1'b0;
         b0      <= 1'b0;
         b1      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         success <= 1'b0;
         fail    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && (state == PRESS || state == GAP || state == WAIT)) begin
            // Abort leaves success/fail at the zero they were cleared to on start.
            state <= IDLE;
            b0    <= 1'b0;
            b1    <= 1'b0;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !abort) begin
                     shreg   <= code;
                     bit_idx <= IW'(CODE_LEN - 1);
                     cnt     <= CW'(1);
                     seen    <= 1'b0;
                     success <= 1'b0;
                     fail    <= 1'b0;
                     busy    <= 1'b1;
                     b1      <= code[CODE_LEN-1];
                     b0      <= ~code[CODE_LEN-1];
                     state   <= PRESS;
                  end
               end
               PRESS: begin
                  // Unlock before the final bit is pressed is stale and ignored.
                  if (unlock && last_bit) seen <= 1'b1;
                  if (cnt == CW'(PRESS_CYCLES)) begin
                     shreg <= next_shreg;
                     cnt   <= CW'(1);
                     if (GAP_CYCLES > 0) begin
                        b0    <= 1'b0;
                        b1    <= 1'b0;
                        state <= GAP;
                     end else if (last_bit) begin
                        b0    <= 1'b0;
                        b1    <= 1'b0;
                        state <= WAIT;
                     end else begin
                        bit_idx <= bit_idx - IW'(1);
                        b1      <= next_bit;
                        b0      <= ~next_bit;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               GAP: begin
                  if (unlock && last_bit) seen <= 1'b1;
                  if (cnt == CW'(GAP_CYCLES)) begin
                     cnt <= CW'(1);
                     if (last_bit) begin
                        state <= WAIT;
                     end else begin
                        bit_idx <= bit_idx - IW'(1);
                        b1      <= shreg[CODE_LEN-1];
                        b0      <= ~shreg[CODE_LEN-1];
                        state   <= PRESS;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               WAIT: begin
                  // Success takes priority over a timeout on the same edge.
                  if (seen || unlock) begin
                     success <= 1'b1;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state   <= DONE;
                  end else if (cnt == CW'(TIMEOUT)) begin
                     fail  <= 1'b1;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
